// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point FFT front end.
// Build option FFT_LOADER_PRESCALE_EN: stored samples are halved (s >>> 1) for butterfly headroom.
package fft_pkg;

  localparam int unsigned N         = 16;
  localparam int unsigned Q         = 8;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned IDX_W     = 3;

  typedef struct packed {
    logic signed [N-1:0] re;
    logic signed [N-1:0] im;
  } cplx_t;

  // W8^k stage-1 twiddles scaled by 2^Q; diagonal term is 2^Q/sqrt2 rounded to nearest
  localparam int TW_ONE  = 1 << Q;
  localparam int TW_DIAG = int'(real'(TW_ONE) * 0.7071067811865476);

  localparam cplx_t W8_0 = '{re: N'(TW_ONE),   im: N'(0)};
  localparam cplx_t W8_1 = '{re: N'(TW_DIAG),  im: N'(-TW_DIAG)};
  localparam cplx_t W8_2 = '{re: N'(0),        im: N'(-TW_ONE)};
  localparam cplx_t W8_3 = '{re: N'(-TW_DIAG), im: N'(-TW_DIAG)};

  function automatic cplx_t loader_store(input cplx_t s);
    cplx_t v;
`ifdef FFT_LOADER_PRESCALE_EN
    v.re = $signed(s.re) >>> 1;
    v.im = $signed(s.im) >>> 1;
`else
    v = s;
`endif
    return v;
  endfunction

endpackage

// File: rtl/fft8_frame_loader_if.sv
// Sample-stream input and parallel-frame output bundle of the FFT8 frame loader.
interface fft8_frame_loader_if;
  import fft_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic                s_last;
  logic signed [N-1:0] s_r;
  logic signed [N-1:0] s_i;

  logic                m_valid;
  logic                m_ready;
  logic signed [N-1:0] x0_r, x1_r, x2_r, x3_r, x4_r, x5_r, x6_r, x7_r;
  logic signed [N-1:0] x0_i, x1_i, x2_i, x3_i, x4_i, x5_i, x6_i, x7_i;
  logic signed [N-1:0] tw1_r, tw1_i, tw2_r, tw2_i, tw3_r, tw3_i, tw4_r, tw4_i;
  logic                frame_err;

  modport slave (
    input  s_valid, s_last, s_r, s_i, m_ready,
    output s_ready, m_valid,
    output x0_r, x1_r, x2_r, x3_r, x4_r, x5_r, x6_r, x7_r,
    output x0_i, x1_i, x2_i, x3_i, x4_i, x5_i, x6_i, x7_i,
    output tw1_r, tw1_i, tw2_r, tw2_i, tw3_r, tw3_i, tw4_r, tw4_i,
    output frame_err
  );

  modport master (
    output s_valid, s_last, s_r, s_i, m_ready,
    input  s_ready, m_valid,
    input  x0_r, x1_r, x2_r, x3_r, x4_r, x5_r, x6_r, x7_r,
    input  x0_i, x1_i, x2_i, x3_i, x4_i, x5_i, x6_i, x7_i,
    input  tw1_r, tw1_i, tw2_r, tw2_i, tw3_r, tw3_i, tw4_r, tw4_i,
    input  frame_err
  );

endinterface

// File: rtl/fft8_frame_bank.sv
// One 8-entry complex register bank: single indexed write port, full parallel read.
module fft8_frame_bank
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  cplx_t            wdata,
  output cplx_t            rdata [FRAME_LEN]
);

  cplx_t mem_q [FRAME_LEN];
  cplx_t mem_d [FRAME_LEN];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[widx] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rdata = mem_q;

endmodule

// File: rtl/fft8_frame_loader.sv
// Collects a serial complex stream into 8-sample frames in a ping-pong buffer and presents
// each frame in parallel with the W8 stage-1 twiddles. Option: FFT_LOADER_PRESCALE_EN (see fft_pkg).
module fft8_frame_loader
  import fft_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  fft8_frame_loader_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             frame_err_q, frame_err_d;

  logic             accept_c;
  logic             release_c;
  logic [1:0]       bank_we;
  cplx_t            wdata;
  cplx_t            rd0 [FRAME_LEN];
  cplx_t            rd1 [FRAME_LEN];
  cplx_t            rd_sel [FRAME_LEN];

  assign bus.s_ready = ~bank_full_q[wr_bank_q];
  assign bus.m_valid = bank_full_q[rd_bank_q];
  assign accept_c    = bus.s_valid & ~bank_full_q[wr_bank_q];
  assign release_c   = bus.m_ready & bank_full_q[rd_bank_q];
  assign wdata       = loader_store('{re: bus.s_r, im: bus.s_i});

  // Fill and release never touch the same bank, so both bit updates can apply together
  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    bank_full_d = bank_full_q;
    frame_err_d = 1'b0;
    bank_we     = 2'b00;
    if (accept_c) begin
      bank_we[wr_bank_q] = 1'b1;
      if (wr_idx_q == LAST_IDX) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        wr_idx_d               = '0;
        frame_err_d            = ~bus.s_last;
      end else if (bus.s_last) begin
        wr_idx_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        wr_idx_d = IDX_W'(wr_idx_q + 1'b1);
      end
    end
    if (release_c) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      bank_full_q <= 2'b00;
      frame_err_q <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      bank_full_q <= bank_full_d;
      frame_err_q <= frame_err_d;
    end
  end

  fft8_frame_bank u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we[0]),
    .widx  (wr_idx_q),
    .wdata (wdata),
    .rdata (rd0)
  );

  fft8_frame_bank u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we[1]),
    .widx  (wr_idx_q),
    .wdata (wdata),
    .rdata (rd1)
  );

  always_comb begin
    if (rd_bank_q) rd_sel = rd1;
    else           rd_sel = rd0;
  end

  assign bus.x0_r = rd_sel[0].re;
  assign bus.x1_r = rd_sel[1].re;
  assign bus.x2_r = rd_sel[2].re;
  assign bus.x3_r = rd_sel[3].re;
  assign bus.x4_r = rd_sel[4].re;
  assign bus.x5_r = rd_sel[5].re;
  assign bus.x6_r = rd_sel[6].re;
  assign bus.x7_r = rd_sel[7].re;
  assign bus.x0_i = rd_sel[0].im;
  assign bus.x1_i = rd_sel[1].im;
  assign bus.x2_i = rd_sel[2].im;
  assign bus.x3_i = rd_sel[3].im;
  assign bus.x4_i = rd_sel[4].im;
  assign bus.x5_i = rd_sel[5].im;
  assign bus.x6_i = rd_sel[6].im;
  assign bus.x7_i = rd_sel[7].im;

  assign bus.tw1_r = W8_0.re;
  assign bus.tw1_i = W8_0.im;
  assign bus.tw2_r = W8_1.re;
  assign bus.tw2_i = W8_1.im;
  assign bus.tw3_r = W8_2.re;
  assign bus.tw3_i = W8_2.im;
  assign bus.tw4_r = W8_3.re;
  assign bus.tw4_i = W8_3.im;

  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Directed self-checking bench for fft8_frame_loader; expected values follow FFT_LOADER_PRESCALE_EN.
module tb_fft8_frame_loader;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   stalls;

  fft8_frame_loader_if bus();

  fft8_frame_loader u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pre(input int v);
`ifdef FFT_LOADER_PRESCALE_EN
    return v >>> 1;
`else
    return v;
`endif
  endfunction

  function automatic int xr(input int k);
    case (k)
      0: return int'(bus.x0_r);  1: return int'(bus.x1_r);
      2: return int'(bus.x2_r);  3: return int'(bus.x3_r);
      4: return int'(bus.x4_r);  5: return int'(bus.x5_r);
      6: return int'(bus.x6_r);  default: return int'(bus.x7_r);
    endcase
  endfunction

  function automatic int xi(input int k);
    case (k)
      0: return int'(bus.x0_i);  1: return int'(bus.x1_i);
      2: return int'(bus.x2_i);  3: return int'(bus.x3_i);
      4: return int'(bus.x4_i);  5: return int'(bus.x5_i);
      6: return int'(bus.x6_i);  default: return int'(bus.x7_i);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Offer one sample and return one step after the edge that accepted it
  task automatic send(input int r, input int i, input bit last);
    bit acc;
    bus.s_valid = 1'b1;
    bus.s_r     = N'(r);
    bus.s_i     = N'(i);
    bus.s_last  = last;
    for (int t = 0; t < 50; t++) begin
      acc = bus.s_ready;
      step();
      if (acc) return;
    end
    check("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    idle();
    bus.m_ready = 1'b0;
    bus.s_r     = '0;
    bus.s_i     = '0;
    rst_n       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_r     = '0;
    bus.s_i     = '0;
    bus.m_ready = 1'b0;
    #2;
    do_reset();

    // reset state and constant twiddles
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_frame_err", bus.frame_err, 0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rst_x%0d_r", k), xr(k), 0);
      check($sformatf("rst_x%0d_i", k), xi(k), 0);
    end
    check("tw1_r", int'(bus.tw1_r), 256);
    check("tw1_i", int'(bus.tw1_i), 0);
    check("tw2_r", int'(bus.tw2_r), 181);
    check("tw2_i", int'(bus.tw2_i), -181);
    check("tw3_r", int'(bus.tw3_r), 0);
    check("tw3_i", int'(bus.tw3_i), -256);
    check("tw4_r", int'(bus.tw4_r), -181);
    check("tw4_i", int'(bus.tw4_i), -181);

    // single frame, m_valid one cycle after the 8th accept, held for exactly one cycle
    bus.m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(k * 256, -k * 256, k == 8);
      if (k == 7) check("f1_mv_early", bus.m_valid, 0);
    end
    check("f1_m_valid", bus.m_valid, 1);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("f1_x%0d_r", k - 1), xr(k - 1), pre(k * 256));
      check($sformatf("f1_x%0d_i", k - 1), xi(k - 1), pre(-k * 256));
    end
    idle();
    step();
    check("f1_mv_drop", bus.m_valid, 0);

    // back-pressure: both banks fill, s_ready drops, releases in order
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 8; k++)
        send(100 * (f + 1) + k, -(100 * (f + 1) + k), k == 7);
    check("bp_s_ready_full", bus.s_ready, 0);
    check("bp_m_valid", bus.m_valid, 1);
    check("bp_fa_x0_r", xr(0), pre(100));
    check("bp_fa_x7_r", xr(7), pre(107));
    bus.s_valid = 1'b1;
    bus.s_r     = N'(300);
    bus.s_i     = N'(0);
    bus.s_last  = 1'b0;
    repeat (3) step();
    check("bp_s_ready_hold", bus.s_ready, 0);
    check("bp_fa_stable", xr(0), pre(100));
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    check("bp_s_ready_back", bus.s_ready, 1);
    check("bp_m_valid_b", bus.m_valid, 1);
    check("bp_fb_x0_r", xr(0), pre(200));
    check("bp_fb_x7_i", xi(7), pre(-207));
    step();
    idle();
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    check("bp_m_valid_done", bus.m_valid, 0);

    // continuous stream, no stalls, m_valid every 8 cycles
    do_reset();
    bus.m_ready = 1'b1;
    stalls      = 0;
    for (int c = 0; c < 32; c++) begin
      bus.s_valid = 1'b1;
      bus.s_r     = N'(c);
      bus.s_i     = N'(0);
      bus.s_last  = (c % 8 == 7);
      if (!bus.s_ready) stalls++;
      step();
      check($sformatf("cont_mv%0d", c), bus.m_valid, int'(c % 8 == 7));
      if (c % 8 == 7) check($sformatf("cont_x0_%0d", c), xr(0), pre(c - 7));
    end
    check("cont_stalls", stalls, 0);
    idle();
    step();

    // early s_last discards the partial frame
    do_reset();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 5; k++) send(k + 1, k + 1, k == 4);
    check("early_err", bus.frame_err, 1);
    check("early_mv", bus.m_valid, 0);
    idle();
    step();
    check("early_err_clr", bus.frame_err, 0);
    check("early_mv2", bus.m_valid, 0);
    for (int k = 0; k < 8; k++) send(50 + k, 60 + k, k == 7);
    check("rec_mv", bus.m_valid, 1);
    check("rec_err", bus.frame_err, 0);
    check("rec_x0_r", xr(0), pre(50));
    check("rec_x4_r", xr(4), pre(54));
    check("rec_x7_i", xi(7), pre(67));
    idle();
    step();

    // missing s_last still completes the frame but flags it
    for (int k = 0; k < 8; k++) send(70 + k, 0, 1'b0);
    check("nolast_err", bus.frame_err, 1);
    check("nolast_mv", bus.m_valid, 1);
    check("nolast_x0_r", xr(0), pre(70));
    idle();
    step();
    check("nolast_err_clr", bus.frame_err, 0);

    // reset mid-frame, then a frame with negative/odd values
    do_reset();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(900 + k, 900 + k, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mv_low", bus.m_valid, 0);
    check("midrst_rdy_low", bus.s_ready, 1);
    step();
    rst_n = 1'b1;
    check("midrst_mv", bus.m_valid, 0);
    check("midrst_rdy", bus.s_ready, 1);
    check("midrst_err", bus.frame_err, 0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("midrst_x%0d_r", k), xr(k), 0);
      check($sformatf("midrst_x%0d_i", k), xi(k), 0);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 2) send(-3, 5, 1'b0);
      else        send(10 * k + 1, -(10 * k + 1), k == 7);
    end
    check("ps_mv", bus.m_valid, 1);
    check("ps_x0_r", xr(0), pre(1));
    check("ps_x2_r", xr(2), pre(-3));
    check("ps_x2_i", xi(2), pre(5));
    check("ps_x7_r", xr(7), pre(71));
    check("ps_x7_i", xi(7), pre(-71));
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft8_frame_loader.md
Name: fft8_frame_loader

Overview:
- Upstream stage of the 8-point radix-2 first-stage butterfly block.
- Accepts a serial stream of complex fixed-point samples over a valid/ready handshake and collects them into 8-sample frames in a two-bank ping-pong buffer.
- Presents one full frame in parallel as x0..x7, together with the constant stage-1 twiddles W8^0..W8^3, under its own valid/ready handshake.

Parameters:
- N, 16, sample and twiddle word width (signed, two's complement).
- Q, 8, fractional bits; twiddle constants are scaled by 2^Q.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input sample valid.
- s_ready  output  1  loader can accept a sample.
- s_last  input  1  marks the 8th sample of a frame.
- s_r  input  N  input sample, real part, signed.
- s_i  input  N  input sample, imaginary part, signed.
- m_valid  output  1  full frame presented on x outputs.
- m_ready  input  1  downstream consumed the frame.
- x0_r..x7_r  output  N each  frame sample k, real part.
- x0_i..x7_i  output  N each  frame sample k, imaginary part.
- tw1_r/tw1_i..tw4_r/tw4_i  output  N each  constants W8^0..W8^3.
- frame_err  output  1  one-cycle pulse on an s_last framing mismatch.

Behaviour:
- Reset is asynchronous, active-low, and fixed for this block. While rst_n=0:
  - wr_bank=0, rd_bank=0, wr_idx=0, bank_full=2'b00, frame_err=0.
  - Bank contents are cleared to 0.
  - Resulting outputs: s_ready=1, m_valid=0, x outputs = 0.
- Twiddles are constant and independent of reset:
  - tw1 = (2^Q, 0)
  - tw2 = (round(2^Q/sqrt2), -round(2^Q/sqrt2)); for Q=8 this is (181,-181).
  - tw3 = (0, -2^Q)
  - tw4 = (-181, -181) for Q=8.
- Handshake outputs:
  - s_ready = !bank_full[wr_bank].
  - m_valid = bank_full[rd_bank].
- Input accept (s_valid & s_ready):
  - The sample is written to bank[wr_bank][wr_idx] and wr_idx increments.
  - At wr_idx=7: bank_full[wr_bank]<=1, wr_bank toggles, wr_idx<=0.
- Output outputs and consume:
  - x outputs are driven from bank[rd_bank], registered storage with a combinational bank mux. They are stable while m_valid=1 and m_ready=0.
  - On m_valid & m_ready: bank_full[rd_bank]<=0 and rd_bank toggles.
- Latency: last sample accepted in cycle T gives m_valid=1 in T+1. Minimum frame period is 8 cycles. With m_ready held at 1, the stream runs continuously with no bubbles.
- Framing and error rules:
  - Sample order is natural: sample k maps to xk. The first sample after reset or after a frame completes is x0.
  - s_last accepted with wr_idx<7: the partial frame is discarded, wr_idx<=0, bank_full is unchanged, frame_err pulses for 1 cycle.
  - wr_idx=7 accepted with s_last=0: the frame still completes normally, and frame_err pulses for 1 cycle.
- Simultaneous events:
  - Filling bank A and releasing bank B in the same cycle is legal; both updates take effect.
  - The same bank can never be both filled and released in one cycle.
- Full condition: when both banks are full, s_ready=0. s_ready returns to 1 in the cycle after the release handshake.
- Reset asserted mid-frame aborts everything immediately. Partial and full frames are lost, and there is no frame_err pulse.
- Arithmetic: no arithmetic is performed in the default build; samples pass through bit-exact.

Optional Feature:
- Macro: FFT_LOADER_PRESCALE_EN.
- Defined: each accepted sample is stored as s >>> 1 (arithmetic shift, floor rounding) to give the butterfly stage one bit of growth headroom. Example: s_r = -3 is stored as -2.
- Undefined: samples are stored unmodified.
- Interface and timing are identical in both builds.

Decomposition:
- Shared package fft_pkg holds:
  - the complex sample type;
  - the W8^k twiddle constants, derived from N and Q;
  - FRAME_LEN=8 and IDX_W=3.
- One sub-module is natural: fft8_frame_bank, a single 8-entry complex register bank with a write port and a parallel read. It is instantiated twice and selected by rd_bank.

Test Plan:
- Reset, then stream samples 1..8 (s_r=k*256, s_i=-k*256) with s_last on the 8th and m_ready=1 → m_valid for exactly 1 cycle, one cycle after the 8th accept. Outputs x0_r=256 .. x7_r=2048, tw2=(181,-181).
- m_ready=0 while 3 frames are offered → 2 frames are accepted, then s_ready=0 from the 17th sample onward. Raise m_ready → frame 1 is presented, then frame 2, with s_ready returning 1 cycle after the first release.
- Continuous stream with m_ready=1 and s_valid=1 → s_ready is never deasserted and m_valid pulses every 8 cycles.
- s_last on the 5th sample → frame_err pulses 1 cycle, no m_valid, and the next 8 samples form a correct frame starting at x0.
- Pull rst_n low after 4 of 8 samples, then release → m_valid=0, s_ready=1, x outputs all 0, and the next frame starts at x0.
- With FFT_LOADER_PRESCALE_EN defined, a frame containing s_r=-3 and s_i=5 → -2 and 2 appear on the corresponding x outputs.
